// File: rtl/dtcore32_scoreboard_if.sv
// Bundle between the ID/completion/flush logic and the register scoreboard.
// Master drives ID, completion and kill information; the slave (scoreboard) returns stall, slot and status.
interface dtcore32_scoreboard_if #(
  parameter int NUM_SLOTS  = 4,
  parameter int REG_ADDR_W = 5
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                  ID_valid_i;
  logic [REG_ADDR_W-1:0] ID_rs1_addr_i;
  logic [REG_ADDR_W-1:0] ID_rs2_addr_i;
  logic                  ID_rs1_used_i;
  logic                  ID_rs2_used_i;
  logic [REG_ADDR_W-1:0] ID_rd_addr_i;
  logic                  ID_ll_i;
  logic                  ID_flush_i;
  logic                  ID_stall_o;
  logic [SLOT_W-1:0]     ID_slot_o;
  logic                  cmpl_valid_i;
  logic [SLOT_W-1:0]     cmpl_slot_i;
  logic [NUM_SLOTS-1:0]  kill_mask_i;
  logic                  flush_all_i;
  logic [NUM_SLOTS-1:0]  busy_mask_o;
  logic                  full_o;
  logic                  err_o;
  logic [31:0]           stall_cycles_o;

  modport master (
    output ID_valid_i, ID_rs1_addr_i, ID_rs2_addr_i, ID_rs1_used_i, ID_rs2_used_i,
    output ID_rd_addr_i, ID_ll_i, ID_flush_i,
    output cmpl_valid_i, cmpl_slot_i, kill_mask_i, flush_all_i,
    input  ID_stall_o, ID_slot_o, busy_mask_o, full_o, err_o, stall_cycles_o
  );

  modport slave (
    input  ID_valid_i, ID_rs1_addr_i, ID_rs2_addr_i, ID_rs1_used_i, ID_rs2_used_i,
    input  ID_rd_addr_i, ID_ll_i, ID_flush_i,
    input  cmpl_valid_i, cmpl_slot_i, kill_mask_i, flush_all_i,
    output ID_stall_o, ID_slot_o, busy_mask_o, full_o, err_o, stall_cycles_o
  );
endinterface

// File: rtl/dtcore32_scoreboard.sv
// Register scoreboard tracking in-flight long-latency writes (loads, CSR reads, mul/div).
// Optional stall statistics counter enabled by defining DTCORE32_SB_STATS_EN.
module dtcore32_scoreboard #(
  parameter int NUM_SLOTS  = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dtcore32_scoreboard_if.slave sb
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q [NUM_SLOTS];
  logic [REG_ADDR_W-1:0] rd_d [NUM_SLOTS];
  logic                  err_q;
  logic                  err_set;

  logic                  raw, rd_match, long_rd, waw, nofree, full, stall, alloc;
  logic                  free_found;
  logic [SLOT_W-1:0]     free_idx;
  logic                  cmpl_in_range;

  // Hazards look only at registered slots, so a same-cycle free unstalls one cycle late.
  always_comb begin
    raw      = 1'b0;
    rd_match = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (valid_q[k]) begin
        if (sb.ID_rs1_used_i && (sb.ID_rs1_addr_i != '0) && (rd_q[k] == sb.ID_rs1_addr_i))
          raw = 1'b1;
        if (sb.ID_rs2_used_i && (sb.ID_rs2_addr_i != '0) && (rd_q[k] == sb.ID_rs2_addr_i))
          raw = 1'b1;
        if (rd_q[k] == sb.ID_rd_addr_i)
          rd_match = 1'b1;
      end
    end
  end

  // Scan downward so the lowest free index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(k);
      end
    end
  end

  assign full    = &valid_q;
  assign long_rd = sb.ID_ll_i && (sb.ID_rd_addr_i != '0);
  assign waw     = long_rd && rd_match;
  assign nofree  = long_rd && full;
  assign stall   = sb.ID_valid_i && (raw || waw || nofree);
  assign alloc   = sb.ID_valid_i && long_rd && !stall && !sb.ID_flush_i && free_found;

  assign cmpl_in_range = (32'(sb.cmpl_slot_i) < 32'(NUM_SLOTS));

  // flush_all dominates; kill and completion both clear; alloc uses a slot free before this edge.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    err_set = 1'b0;
    if (sb.flush_all_i) begin
      valid_d = '0;
    end else begin
      valid_d = valid_q & ~sb.kill_mask_i;
      if (sb.cmpl_valid_i) begin
        if (cmpl_in_range && valid_q[sb.cmpl_slot_i])
          valid_d[sb.cmpl_slot_i] = 1'b0;
        else
          err_set = 1'b1;
      end
      if (alloc) begin
        valid_d[free_idx] = 1'b1;
        rd_d[free_idx]    = sb.ID_rd_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++)
        rd_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_q | err_set;
      for (int k = 0; k < NUM_SLOTS; k++)
        rd_q[k] <= rd_d[k];
    end
  end

  assign sb.ID_stall_o  = stall;
  assign sb.ID_slot_o   = free_found ? free_idx : '0;
  assign sb.busy_mask_o = valid_q;
  assign sb.full_o      = full;
  assign sb.err_o       = err_q;

`ifdef DTCORE32_SB_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating; flush_all deliberately leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign sb.stall_cycles_o = stall_cnt_q;
`else
  assign sb.stall_cycles_o = 32'd0;
`endif
endmodule

// File: tb/tb_dtcore32_scoreboard.sv
// Bench for dtcore32_scoreboard: directed vector table, hand sequences for reset/stats,
// and random traffic against an in-flight-list reference model.
module tb_dtcore32_scoreboard;
  localparam int NUM_SLOTS  = 4;
  localparam int REG_ADDR_W = 5;
  localparam int SLOT_W     = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dtcore32_scoreboard_if #(.NUM_SLOTS(NUM_SLOTS), .REG_ADDR_W(REG_ADDR_W)) sb ();

  dtcore32_scoreboard #(.NUM_SLOTS(NUM_SLOTS), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: list of in-flight producers
  typedef struct { int slot; int rd; } entry_t;
  entry_t              m_q[$];
  bit                  m_err;
  logic [31:0]         m_cnt;
  logic [NUM_SLOTS-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_has_slot(int s);
    foreach (m_q[i]) if (m_q[i].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free();
    for (int s = 0; s < NUM_SLOTS; s++) if (!m_has_slot(s)) return s;
    return 0;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] m_busy();
    logic [NUM_SLOTS-1:0] m = '0;
    foreach (m_q[i]) m[m_q[i].slot] = 1'b1;
    return m;
  endfunction

  function automatic bit m_stall();
    bit raw = 1'b0;
    bit hit = 1'b0;
    bit lng;
    foreach (m_q[i]) begin
      if (sb.ID_rs1_used_i && sb.ID_rs1_addr_i != 0 && m_q[i].rd == int'(sb.ID_rs1_addr_i)) raw = 1'b1;
      if (sb.ID_rs2_used_i && sb.ID_rs2_addr_i != 0 && m_q[i].rd == int'(sb.ID_rs2_addr_i)) raw = 1'b1;
      if (m_q[i].rd == int'(sb.ID_rd_addr_i)) hit = 1'b1;
    end
    lng = sb.ID_ll_i && (sb.ID_rd_addr_i != 0);
    return sb.ID_valid_i && (raw || (lng && (hit || m_q.size() == NUM_SLOTS)));
  endfunction

  function automatic logic [31:0] m_exp_cnt();
`ifdef DTCORE32_SB_STATS_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic m_reset();
    m_q.delete();
    exp_q.delete();
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  // driver tasks
  task automatic drive(input bit v, input int rs1, input bit r1u, input int rs2, input bit r2u,
                       input int rd, input bit ll, input bit idf, input bit cv, input int cs,
                       input logic [NUM_SLOTS-1:0] kill, input bit fa);
    sb.ID_valid_i    = v;
    sb.ID_rs1_addr_i = REG_ADDR_W'(rs1);
    sb.ID_rs1_used_i = r1u;
    sb.ID_rs2_addr_i = REG_ADDR_W'(rs2);
    sb.ID_rs2_used_i = r2u;
    sb.ID_rd_addr_i  = REG_ADDR_W'(rd);
    sb.ID_ll_i       = ll;
    sb.ID_flush_i    = idf;
    sb.cmpl_valid_i  = cv;
    sb.cmpl_slot_i   = SLOT_W'(cs);
    sb.kill_mask_i   = kill;
    sb.flush_all_i   = fa;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic check_comb(input string tag);
    chk({tag, "_stall"}, sb.ID_stall_o, m_stall());
    chk({tag, "_slot"}, sb.ID_slot_o, m_free());
  endtask

  // Advance one clock: model applies the cycle's rules, then DUT state is compared.
  task automatic tick(input string tag);
    bit st, al;
    int fs;
    entry_t nq[$];
    st = m_stall();
    fs = m_free();
    al = sb.ID_valid_i && sb.ID_ll_i && (sb.ID_rd_addr_i != 0) && !st && !sb.ID_flush_i;
    if (sb.flush_all_i) begin
      m_q.delete();
    end else begin
      if (sb.cmpl_valid_i && !m_has_slot(int'(sb.cmpl_slot_i))) m_err = 1'b1;
      foreach (m_q[i])
        if (!sb.kill_mask_i[m_q[i].slot] && !(sb.cmpl_valid_i && m_q[i].slot == int'(sb.cmpl_slot_i)))
          nq.push_back(m_q[i]);
      m_q = nq;
      if (al) m_q.push_back('{fs, int'(sb.ID_rd_addr_i)});
    end
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    exp_q.push_back(m_busy());
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, sb.busy_mask_o, exp_q.pop_front());
    chk({tag, "_full"}, sb.full_o, m_q.size() == NUM_SLOTS);
    chk({tag, "_err"}, sb.err_o, m_err);
    chk({tag, "_cnt"}, sb.stall_cycles_o, m_exp_cnt());
  endtask

  typedef struct {
    bit v; int rs1; bit r1u; int rs2; bit r2u; int rd; bit ll; bit idf;
    bit cv; int cs; logic [3:0] kill; bit fa;
    bit e_stall; int e_slot; logic [3:0] e_busy; bit e_err;
  } vec_t;

  vec_t tbl[24];

  initial begin
    tbl[0]  = '{1, 0,0, 0,0,  5, 1,0, 0,0, 4'b0000, 0,  0,0, 4'b0001, 0};
    tbl[1]  = '{1, 5,1, 0,0,  6, 0,0, 0,0, 4'b0000, 0,  1,1, 4'b0001, 0};
    tbl[2]  = '{1, 5,1, 0,0,  6, 0,0, 1,0, 4'b0000, 0,  1,1, 4'b0000, 0};
    tbl[3]  = '{1, 5,1, 0,0,  6, 0,0, 0,0, 4'b0000, 0,  0,0, 4'b0000, 0};
    tbl[4]  = '{1, 0,0, 0,0,  1, 1,0, 0,0, 4'b0000, 0,  0,0, 4'b0001, 0};
    tbl[5]  = '{1, 0,0, 0,0,  2, 1,0, 0,0, 4'b0000, 0,  0,1, 4'b0011, 0};
    tbl[6]  = '{1, 0,0, 0,0,  3, 1,0, 0,0, 4'b0000, 0,  0,2, 4'b0111, 0};
    tbl[7]  = '{1, 0,0, 0,0,  4, 1,0, 0,0, 4'b0000, 0,  0,3, 4'b1111, 0};
    tbl[8]  = '{1, 0,0, 0,0,  6, 1,0, 0,0, 4'b0000, 0,  1,0, 4'b1111, 0};
    tbl[9]  = '{1, 0,0, 0,0,  6, 1,0, 1,2, 4'b0000, 0,  1,0, 4'b1011, 0};
    tbl[10] = '{1, 0,0, 0,0,  6, 1,0, 0,0, 4'b0000, 0,  0,2, 4'b1111, 0};
    tbl[11] = '{0, 0,0, 0,0,  0, 0,0, 0,0, 4'b1111, 0,  0,0, 4'b0000, 0};
    tbl[12] = '{1, 0,0, 0,0,  7, 1,0, 0,0, 4'b0000, 0,  0,0, 4'b0001, 0};
    tbl[13] = '{1, 0,0, 0,0,  7, 1,0, 0,0, 4'b0000, 0,  1,1, 4'b0001, 0};
    tbl[14] = '{1, 0,0, 0,0,  0, 1,0, 0,0, 4'b0000, 0,  0,1, 4'b0001, 0};
    tbl[15] = '{0, 0,0, 0,0,  0, 0,0, 0,0, 4'b0001, 0,  0,1, 4'b0000, 0};
    tbl[16] = '{1, 0,0, 0,0,  8, 1,0, 0,0, 4'b0000, 0,  0,0, 4'b0001, 0};
    tbl[17] = '{1, 0,0, 0,0,  9, 1,0, 0,0, 4'b0000, 0,  0,1, 4'b0011, 0};
    tbl[18] = '{0, 0,0, 0,0,  0, 0,0, 1,0, 4'b0010, 0,  0,2, 4'b0000, 0};
    tbl[19] = '{0, 0,0, 0,0,  0, 0,0, 1,3, 4'b0000, 0,  0,0, 4'b0000, 1};
    tbl[20] = '{0, 0,0, 0,0,  0, 0,0, 0,0, 4'b0000, 0,  0,0, 4'b0000, 1};
    tbl[21] = '{1, 0,0, 0,0, 10, 1,0, 0,0, 4'b0000, 0,  0,0, 4'b0001, 1};
    tbl[22] = '{1, 0,0, 0,0, 11, 1,0, 0,0, 4'b0000, 1,  0,1, 4'b0000, 1};
    tbl[23] = '{1, 0,0, 0,0, 12, 1,1, 0,0, 4'b0000, 0,  0,0, 4'b0000, 1};

    // reset state
    rst = 1'b1;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", sb.busy_mask_o, 4'b0000);
    chk("rst_full", sb.full_o, 1'b0);
    chk("rst_err", sb.err_o, 1'b0);
    chk("rst_stall", sb.ID_stall_o, 1'b0);
    chk("rst_slot", sb.ID_slot_o, 2'd0);
    chk("rst_cnt", sb.stall_cycles_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].r1u, tbl[i].rs2, tbl[i].r2u, tbl[i].rd, tbl[i].ll,
            tbl[i].idf, tbl[i].cv, tbl[i].cs, tbl[i].kill, tbl[i].fa);
      #1;
      chk($sformatf("tbl%0d_stall", i), sb.ID_stall_o, tbl[i].e_stall);
      chk($sformatf("tbl%0d_slot", i), sb.ID_slot_o, tbl[i].e_slot);
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_busy_c", i), sb.busy_mask_o, tbl[i].e_busy);
      chk($sformatf("tbl%0d_err_c", i), sb.err_o, tbl[i].e_err);
    end
`ifdef DTCORE32_SB_STATS_EN
    chk("tbl_stall_cycles", sb.stall_cycles_o, 32'd5);
`else
    chk("tbl_stall_cycles", sb.stall_cycles_o, 32'd0);
`endif

    // reset asserted while ID is stalled
    drive(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, '0, 0);
    tick("mid_alloc");
    drive(1, 13, 1, 0, 0, 20, 0, 0, 0, 0, '0, 0);
    #1;
    chk("mid_stall_before", sb.ID_stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_stall_rst", sb.ID_stall_o, 1'b0);
    chk("mid_busy_rst", sb.busy_mask_o, 4'b0000);
    chk("mid_err_rst", sb.err_o, 1'b0);
    chk("mid_cnt_rst", sb.stall_cycles_o, 32'd0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;

    // ten stall cycles for the statistics counter
    drive(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, '0, 0);
    tick("st_alloc");
    drive(1, 14, 1, 0, 0, 15, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++) tick("st_hold");
`ifdef DTCORE32_SB_STATS_EN
    chk("stats_ten", sb.stall_cycles_o, 32'd10);
`else
    chk("stats_ten", sb.stall_cycles_o, 32'd0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 0);
    tick("st_cmpl");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit cv;
      int cs;
      logic [NUM_SLOTS-1:0] kill;
      cv = 1'b0;
      cs = 0;
      if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        cv = 1'b1;
        cs = m_q[$urandom_range(0, m_q.size() - 1)].slot;
      end else if ($urandom_range(0, 39) == 0) begin
        cv = 1'b1;
        cs = $urandom_range(0, NUM_SLOTS - 1);
      end
      kill = ($urandom_range(0, 9) == 0) ? NUM_SLOTS'($urandom) : '0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 9) == 0, cv, cs, kill,
            $urandom_range(0, 49) == 0);
      #1;
      check_comb("rnd");
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dtcore32_scoreboard.md
Name: dtcore32_scoreboard

Overview:
Parametrised register scoreboard that replaces fixed stage-compare stalling for long-latency producers: loads, CSR reads, and multi-cycle mul/div.
- Tracks up to NUM_SLOTS in-flight long-latency writes.
- Stalls ID on RAW/WAW conflicts or when no slot is free.
- Frees slots on completion or on kill from flush/trap logic.
- Sits beside the hazard unit. ID_stall_o is ORed into the IF/ID stall.

Parameters:
NUM_SLOTS, 4, maximum outstanding long-latency ops (1..16)
REG_ADDR_W, 5, register address width
SLOT_W, derived localparam = max(1, $clog2(NUM_SLOTS)), slot index width

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
ID_valid_i  in  1  valid instruction in ID
ID_rs1_addr_i  in  REG_ADDR_W  ID source 1
ID_rs2_addr_i  in  REG_ADDR_W  ID source 2
ID_rs1_used_i  in  1  instruction reads rs1
ID_rs2_used_i  in  1  instruction reads rs2
ID_rd_addr_i  in  REG_ADDR_W  ID destination
ID_ll_i  in  1  instruction is long-latency
ID_flush_i  in  1  ID being flushed this cycle (no allocation)
ID_stall_o  out  1  hold IF/ID
ID_slot_o  out  SLOT_W  slot allocated on issue; carried down pipe
cmpl_valid_i  in  1  long-latency result written back this cycle
cmpl_slot_i  in  SLOT_W  slot completing
kill_mask_i  in  NUM_SLOTS  slots whose producers are flushed this cycle
flush_all_i  in  1  clear all slots
busy_mask_o  out  NUM_SLOTS  registered slot-valid bits
full_o  out  1  all slots valid
err_o  out  1  sticky protocol error
stall_cycles_o  out  32  stall statistics (optional feature)

Behaviour:
- Per-slot state: valid bit and rd (REG_ADDR_W). All state is flops on clk_i with async reset on rst_i.
- Reset values:
  - valid=0, rd=0.
  - err_o=0, stall_cycles_o=0.
  - busy_mask_o=0, full_o=0.
  - ID_stall_o=0 while ID_valid_i=0.
- Hazard terms are computed from registered state only. A completion or kill this cycle does not unstall until the next cycle (one-cycle conservative).
- raw: any valid slot whose rd equals ID_rs1_addr_i with ID_rs1_used_i=1 and rs1≠0, or equals ID_rs2_addr_i with ID_rs2_used_i=1 and rs2≠0.
- waw: ID_ll_i=1, ID_rd_addr_i≠0, and any valid slot has rd == ID_rd_addr_i.
- nofree: ID_ll_i=1, ID_rd_addr_i≠0, and full_o=1.
- ID_stall_o = ID_valid_i & (raw | waw | nofree). Purely combinational.
- Issue (alloc) = ID_valid_i & ID_ll_i & (ID_rd_addr_i≠0) & ~ID_stall_o & ~ID_flush_i.
  - On alloc, the lowest-index free slot (registered) takes valid=1 and rd=ID_rd_addr_i.
  - ID_slot_o combinationally shows that index whenever a free slot exists, otherwise 0.
  - Long-latency ops with rd=x0 allocate nothing and never stall on nofree.
- Completion: cmpl_valid_i clears valid[cmpl_slot_i].
  - If that slot is already free or cmpl_slot_i ≥ NUM_SLOTS: no state change, err_o set.
- Kill: every slot with kill_mask_i[k]=1 is cleared. Killing an already-free slot is legal and silent.
- Priority per cycle: rst_i > flush_all_i (clears all valids, inhibits alloc) > kill/completion (both may hit the same slot; result free, no error) > alloc.
- A slot freed this cycle is not reallocated until the next cycle.
- busy_mask_o = valid vector. full_o = &valid.
- err_o stays 1 until rst_i.
- Reset mid-operation: all slots drop immediately (asynchronous). ID_stall_o deasserts in the same cycle.

Optional Feature:
DTCORE32_SB_STATS_EN
- Defined: stall_cycles_o is a 32-bit counter.
  - Increments on each clock edge where ID_stall_o=1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst_i only; not cleared by flush_all_i.
- Undefined: no counter flops; stall_cycles_o tied to 0.

Test Plan:
- Reset, issue load rd=x5 (ll=1); next cycle ID reads rs1=x5 -> ID_stall_o=1, busy_mask_o=0001; cmpl slot 0 -> stall drops the following cycle, busy_mask_o=0000.
- NUM_SLOTS=4: issue 4 loads to x1..x4 back-to-back -> slots 0..3, full_o=1; 5th load to x6 -> stalled; complete slot 2 -> next cycle x6 allocated to slot 2.
- Load to x7 pending, ID load to x7 with no source use -> waw stall; same load with rd=x0 -> no stall, no allocation.
- Slots 0,1 busy; kill_mask_i=0010 with cmpl slot 0 in the same cycle -> busy_mask_o=0000, err_o=0; completion on free slot 3 -> err_o=1 and stays 1.
- flush_all_i with ID alloc pending the same cycle -> busy_mask_o=0000, no allocation. Assert rst_i mid-stall -> ID_stall_o=0 in the same cycle.
- DTCORE32_SB_STATS_EN defined, 10 stall cycles -> stall_cycles_o=10; undefined -> stall_cycles_o stays 0.
